fir_seq_ctrl: RTL and testbench

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

---
 rtl/fir_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_ctrl.sv
// Sequencer for a time-multiplexed FIR: clears the delay line, accepts samples,
// walks taps newest-first and hands one result per sample. Option: FIR_SEQ_CTRL_STALL_CNT_EN.
module fir_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int TAPS  = 8,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [WIDTH-1:0] x_in,
    output logic             buf_we,
    output logic [AW-1:0]    buf_waddr,
    output logic [WIDTH-1:0] buf_wdata,
    output logic [AW-1:0]    buf_raddr,
    output logic [AW-1:0]    coef_raddr,
    output logic             mac_en,
    output logic             mac_clr,
    output logic             acc_latch,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             busy
`ifdef FIR_SEQ_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        LATCH = 3'd4,
        OUT   = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

    state_t          state_r;
    logic [AW-1:0]   sweep_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   base_r;
    logic [AW-1:0]   k_r;
    logic [AW-1:0]   k_inc_s;
    logic            accept_s;

    // Buffer write port is combinational so an accepted sample lands in its own cycle.
    always_comb begin
        accept_s  = (state_r == IDLE) && x_valid && x_ready;
        k_inc_s   = k_r + AW'(1);
        buf_we    = 1'b0;
        buf_waddr = wr_ptr_r;
        buf_wdata = '0;
        if (!rst) begin
            buf_we = 1'b0;
        end else if (state_r == INIT) begin
            buf_we    = 1'b1;
            buf_waddr = sweep_r;
        end else if (accept_s) begin
            buf_we    = 1'b1;
            buf_wdata = x_in;
        end else begin
            buf_we = 1'b0;
        end
    end

    // Control FSM; every registered output is set for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= INIT;
            sweep_r    <= '0;
            wr_ptr_r   <= '0;
            base_r     <= '0;
            k_r        <= '0;
            x_ready    <= 1'b0;
            buf_raddr  <= '0;
            coef_raddr <= '0;
            mac_en     <= 1'b0;
            mac_clr    <= 1'b0;
            acc_latch  <= 1'b0;
            y_valid    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    if (sweep_r == LAST_IDX) begin
                        state_r <= IDLE;
                        x_ready <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        sweep_r <= sweep_r + AW'(1);
                        busy    <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept_s) begin
                        state_r    <= RUN;
                        base_r     <= wr_ptr_r;
                        wr_ptr_r   <= wr_ptr_r + AW'(1);
                        k_r        <= '0;
                        buf_raddr  <= wr_ptr_r;
                        coef_raddr <= '0;
                        x_ready    <= 1'b0;
                        busy       <= 1'b1;
                    end else begin
                        x_ready <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    // MAC strobes trail the read addresses by the datapath read latency.
                    mac_en  <= 1'b1;
                    mac_clr <= (k_r == '0);
                    if (k_r == LAST_IDX) begin
                        state_r <= FLUSH;
                    end else begin
                        k_r        <= k_inc_s;
                        buf_raddr  <= base_r - k_inc_s;
                        coef_raddr <= k_inc_s;
                    end
                end
                FLUSH: begin
                    mac_en    <= 1'b0;
                    mac_clr   <= 1'b0;
                    acc_latch <= 1'b1;
                    state_r   <= LATCH;
                end
                LATCH: begin
                    acc_latch <= 1'b0;
                    y_valid   <= 1'b1;
                    state_r   <= OUT;
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        x_ready <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        y_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= INIT;
                    sweep_r   <= '0;
                    x_ready   <= 1'b0;
                    mac_en    <= 1'b0;
                    mac_clr   <= 1'b0;
                    acc_latch <= 1'b0;
                    y_valid   <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

`ifdef FIR_SEQ_CTRL_STALL_CNT_EN
    // Saturating count of cycles the result waits on the consumer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'h0000;
        end else if (y_valid && !y_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl (TAPS=8, WIDTH=16) with a cycle-schedule reference model.
module tb_fir_seq_ctrl;
    localparam int W = 16;
    localparam int T = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         x_valid = 1'b0;
    logic         x_ready;
    logic [W-1:0] x_in = 16'h0000;
    logic         buf_we;
    logic [2:0]   buf_waddr;
    logic [W-1:0] buf_wdata;
    logic [2:0]   buf_raddr;
    logic [2:0]   coef_raddr;
    logic         mac_en, mac_clr, acc_latch, y_valid, busy;
    logic         y_ready = 1'b0;
`ifdef FIR_SEQ_CTRL_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    fir_seq_ctrl #(.WIDTH(W), .TAPS(T)) dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(x_ready), .x_in(x_in),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .buf_raddr(buf_raddr), .coef_raddr(coef_raddr), .mac_en(mac_en),
        .mac_clr(mac_clr), .acc_latch(acc_latch), .y_valid(y_valid),
        .y_ready(y_ready), .busy(busy)
`ifdef FIR_SEQ_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: modes and sample-relative cycle offsets.
    localparam int M_INIT = 0, M_IDLE = 1, M_PROC = 2, M_OUT = 3;
    int m_mode = M_INIT;
    int m_sweep = 0;
    int m_wp = 0;
    int m_base = 0;
    int m_d = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_x_ready", x_ready, 0);
            check("rst_y_valid", y_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_mac_en", mac_en, 0);
            check("rst_mac_clr", mac_clr, 0);
            check("rst_acc_latch", acc_latch, 0);
            check("rst_buf_raddr", buf_raddr, 0);
            check("rst_coef_raddr", coef_raddr, 0);
            check("rst_buf_we", buf_we, 0);
            m_mode = M_INIT; m_sweep = 0; m_wp = 0;
        end else begin
            case (m_mode)
                M_INIT: begin
                    check("m_init_we", buf_we, 1);
                    check("m_init_waddr", buf_waddr, m_sweep);
                    check("m_init_wdata", buf_wdata, 0);
                    check("m_init_x_ready", x_ready, 0);
                    check("m_init_mac_en", mac_en, 0);
                    m_sweep++;
                    if (m_sweep == T) m_mode = M_IDLE;
                end
                M_IDLE: begin
                    check("m_idle_x_ready", x_ready, 1);
                    check("m_idle_busy", busy, 0);
                    check("m_idle_y_valid", y_valid, 0);
                    check("m_idle_mac_en", mac_en, 0);
                    check("m_idle_acc_latch", acc_latch, 0);
                    check("m_idle_we", buf_we, x_valid);
                    if (x_valid) begin
                        check("m_acc_waddr", buf_waddr, m_wp);
                        check("m_acc_wdata", buf_wdata, x_in);
                        m_base = m_wp;
                        m_wp = (m_wp + 1) % T;
                        m_d = 0;
                        m_mode = M_PROC;
                    end
                end
                M_PROC: begin
                    m_d++;
                    check("m_proc_x_ready", x_ready, 0);
                    check("m_proc_busy", busy, 1);
                    check("m_proc_we", buf_we, 0);
                    check("m_proc_y_valid", y_valid, 0);
                    check("m_proc_mac_en", mac_en, (m_d >= 2 && m_d <= T + 1) ? 1 : 0);
                    check("m_proc_mac_clr", mac_clr, (m_d == 2) ? 1 : 0);
                    check("m_proc_acc_latch", acc_latch, (m_d == T + 2) ? 1 : 0);
                    if (m_d <= T) begin
                        check("m_proc_raddr", buf_raddr, (m_base - (m_d - 1) + T) % T);
                        check("m_proc_coef", coef_raddr, m_d - 1);
                    end
                    if (m_d == T + 2) m_mode = M_OUT;
                end
                M_OUT: begin
                    check("m_out_y_valid", y_valid, 1);
                    check("m_out_x_ready", x_ready, 0);
                    check("m_out_we", buf_we, 0);
                    check("m_out_busy", busy, 1);
                    check("m_out_mac_en", mac_en, 0);
                    check("m_out_acc_latch", acc_latch, 0);
                    if (y_ready) m_mode = M_IDLE;
                end
                default: m_mode = M_INIT;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [2:0] wa,
                        input logic [2:0] r0, input logic [2:0] r1, input bit early);
        int n;
        n = 0;
        while (!x_ready && n < 40) begin step(); n++; end
        check("send_x_ready", x_ready, 1);
        x_valid = 1'b1; x_in = d;
        #1;
        check("send_waddr", buf_waddr, wa);
        step();
        x_valid = 1'b0;
        if (early) y_ready = 1'b1;
        check("send_r0", buf_raddr, r0);
        step();
        check("send_r1", buf_raddr, r1);
        n = 0;
        while (!y_valid && n < 40) begin step(); n++; end
        check("send_y_valid", y_valid, 1);
        y_ready = 1'b1;
        step();
        y_ready = 1'b0;
    endtask

    logic [15:0] s_data [8] = '{16'h2222, 16'h3333, 16'h4444, 16'h5555,
                                16'h6666, 16'h7777, 16'h8888, 16'h9999};
    logic [2:0]  s_wa   [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [2:0]  s_r1   [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    bit          s_early[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        repeat (3) step();
        check("lit_rst_x_ready", x_ready, 0);
        check("lit_rst_buf_we", buf_we, 0);
        rst = 1'b1;
        #1;
        check("lit_init_we", buf_we, 1);
        check("lit_init_addr0", buf_waddr, 0);
        repeat (7) step();
        check("lit_init_addr7", buf_waddr, 7);
        step();
        check("lit_idle_x_ready", x_ready, 1);

        // First sample: full latency schedule.
        x_valid = 1'b1; x_in = 16'h1000;
        #1;
        check("lit_s1_we", buf_we, 1);
        check("lit_s1_waddr", buf_waddr, 0);
        check("lit_s1_wdata", buf_wdata, 16'h1000);
        step();
        x_valid = 1'b0;
        check("lit_s1_raddr_a1", buf_raddr, 0);
        check("lit_s1_mac_en_a1", mac_en, 0);
        step();
        check("lit_s1_raddr_a2", buf_raddr, 7);
        check("lit_s1_coef_a2", coef_raddr, 1);
        check("lit_s1_mac_clr_a2", mac_clr, 1);
        step();
        check("lit_s1_mac_clr_a3", mac_clr, 0);
        repeat (7) step();
        check("lit_s1_acc_latch_a10", acc_latch, 1);
        check("lit_s1_mac_en_a10", mac_en, 0);
        check("lit_s1_y_valid_a10", y_valid, 0);
        step();
        check("lit_s1_y_valid_a11", y_valid, 1);

        // Consumer stall with a pending input.
        x_valid = 1'b1;
        repeat (4) step();
        check("lit_stall_x_ready", x_ready, 0);
        check("lit_stall_we", buf_we, 0);
        step();
        check("lit_stall_y_valid", y_valid, 1);
`ifdef FIR_SEQ_CTRL_STALL_CNT_EN
        check("lit_stall_cnt", stall_cnt, 5);
`endif
        x_valid = 1'b0; y_ready = 1'b1;
        step();
        y_ready = 1'b0;
        check("lit_release_x_ready", x_ready, 1);
        check("lit_release_y_valid", y_valid, 0);

        // Samples 2..9: pointer wrap and newest-first reads.
        for (int i = 0; i < 8; i++) send(s_data[i], s_wa[i], s_wa[i], s_r1[i], s_early[i]);

        // Reset in the middle of RUN (k=3).
        x_valid = 1'b1; x_in = 16'hABCD;
        #1;
        check("lit_s10_waddr", buf_waddr, 1);
        step();
        x_valid = 1'b0;
        repeat (3) step();
        check("lit_s10_raddr_k3", buf_raddr, 6);
        check("lit_s10_coef_k3", coef_raddr, 3);
        rst = 1'b0;
        #1;
        check("lit_midrst_raddr", buf_raddr, 0);
        check("lit_midrst_coef", coef_raddr, 0);
        check("lit_midrst_mac_en", mac_en, 0);
        check("lit_midrst_busy", busy, 0);
        repeat (2) step();
        rst = 1'b1;
        repeat (8) step();
        check("lit_post_x_ready", x_ready, 1);
        send(16'h0F0F, 3'd0, 3'd0, 3'd7, 1'b1);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
